// File: rtl/lane_align_sequencer.sv
// Steps character alignment across the GT RX lanes one lane at a time, retrying on
// timeout, and reports per-lane aligned/failed status plus overall done/error.
module lane_align_sequencer #(
    parameter int NUM_LANES      = 4,
    parameter int TIMEOUT_CYCLES = 4096,
    parameter int STABLE_CYCLES  = 16,
    parameter int MAX_RETRIES    = 3
) (
    input  logic                     usr_clk,
    input  logic                     reset,
    input  logic                     start,
    input  logic [32*NUM_LANES-1:0]  rxdata,
    output logic [NUM_LANES-1:0]     en_char_align,
    output logic [NUM_LANES-1:0]     lane_aligned,
    output logic [NUM_LANES-1:0]     lane_failed,
    output logic                     busy,
    output logic                     done,
    output logic                     error
);
    localparam int LW  = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
    localparam int TW0 = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
    // The gap phase reuses the timer to count to 3, so it needs at least 2 bits.
    localparam int TW  = (TW0 < 2) ? 2 : TW0;
    localparam int SW  = $clog2(STABLE_CYCLES + 1);

    localparam logic [31:0]   COMMA = 32'hBCBCBCBC;
    localparam logic [LW-1:0] LAST  = LW'(NUM_LANES - 1);
    localparam logic [TW-1:0] TMAX  = TW'(TIMEOUT_CYCLES - 1);
    localparam logic [TW-1:0] GMAX  = TW'(3);
    localparam logic [SW-1:0] SMAX  = SW'(STABLE_CYCLES - 1);
    localparam logic [3:0]    RMAX  = 4'(MAX_RETRIES);

    typedef enum logic [1:0] {IDLE, WAIT_LOCK, GAP} state_t;

    state_t                 state_q, state_d;
    logic [LW-1:0]          lane_q, lane_d;
    logic [TW-1:0]          timer_q, timer_d;
    logic [SW-1:0]          stable_q, stable_d;
    logic [3:0]             retry_q, retry_d;
    logic [NUM_LANES-1:0]   en_q, en_d, aligned_q, aligned_d, failed_q, failed_d;
    logic                   busy_q, busy_d, done_q, done_d, error_q, error_d;
    logic [31:0]            cur_word;
    logic                   match, adv;

    always_comb begin
        cur_word = '0;
        for (int i = 0; i < NUM_LANES; i++)
            if (lane_q == LW'(i)) cur_word = rxdata[32*i +: 32];
    end

    assign match = (cur_word == COMMA);

    always_comb begin
        state_d   = state_q;
        lane_d    = lane_q;
        timer_d   = timer_q;
        stable_d  = stable_q;
        retry_d   = retry_q;
        en_d      = en_q;
        aligned_d = aligned_q;
        failed_d  = failed_q;
        done_d    = done_q;
        error_d   = error_q;
        adv       = 1'b0;

        case (state_q)
            IDLE: begin
                if (start) begin
                    lane_d    = '0;
                    retry_d   = '0;
                    timer_d   = '0;
                    stable_d  = '0;
                    aligned_d = '0;
                    failed_d  = '0;
                    done_d    = 1'b0;
                    error_d   = 1'b0;
                    en_d      = NUM_LANES'(1);
                    state_d   = WAIT_LOCK;
                end
            end
            WAIT_LOCK: begin
                stable_d = match ? stable_q + 1'b1 : '0;
                timer_d  = timer_q + 1'b1;
                // Lock is checked first so it wins over a coincident timeout.
                if (match && stable_q == SMAX) begin
                    aligned_d[lane_q] = 1'b1;
                    adv = 1'b1;
                end else if (timer_q == TMAX) begin
                    if (retry_q == RMAX) begin
                        failed_d[lane_q] = 1'b1;
                        adv = 1'b1;
                    end else begin
                        retry_d = retry_q + 1'b1;
                        en_d    = '0;
                        timer_d = '0;
                        state_d = GAP;
                    end
                end
            end
            GAP: begin
                timer_d = timer_q + 1'b1;
                if (timer_q == GMAX) begin
                    timer_d  = '0;
                    stable_d = '0;
                    en_d     = NUM_LANES'(1) << lane_q;
                    state_d  = WAIT_LOCK;
                end
            end
            default: state_d = IDLE;
        endcase

        if (adv) begin
            en_d = '0;
            if (lane_q == LAST) begin
                state_d = IDLE;
                done_d  = 1'b1;
                error_d = |failed_d;
            end else begin
                lane_d   = lane_q + 1'b1;
                retry_d  = '0;
                timer_d  = '0;
                stable_d = '0;
                en_d     = NUM_LANES'(1) << lane_d;
            end
        end

        busy_d = (state_d != IDLE);
    end

    always_ff @(posedge usr_clk) begin
        if (reset) begin
            state_q   <= IDLE;
            lane_q    <= '0;
            timer_q   <= '0;
            stable_q  <= '0;
            retry_q   <= '0;
            en_q      <= '0;
            aligned_q <= '0;
            failed_q  <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
            error_q   <= 1'b0;
        end else begin
            state_q   <= state_d;
            lane_q    <= lane_d;
            timer_q   <= timer_d;
            stable_q  <= stable_d;
            retry_q   <= retry_d;
            en_q      <= en_d;
            aligned_q <= aligned_d;
            failed_q  <= failed_d;
            busy_q    <= busy_d;
            done_q    <= done_d;
            error_q   <= error_d;
        end
    end

    assign en_char_align = en_q;
    assign lane_aligned  = aligned_q;
    assign lane_failed   = failed_q;
    assign busy          = busy_q;
    assign done          = done_q;
    assign error         = error_q;
endmodule

// File: tb/tb_lane_align_sequencer.sv
// Directed bench for lane_align_sequencer: 4 lanes, 64-cycle attempts, 16-word lock, 2 retries.
module tb_lane_align_sequencer;
    localparam logic [31:0] COMMA = 32'hBCBCBCBC;
    localparam logic [31:0] BAD   = 32'h12345678;

    logic        usr_clk = 1'b0;
    logic        reset   = 1'b1;
    logic        start   = 1'b0;
    logic [31:0] lane_data [4];
    logic [127:0] rxdata;
    logic [3:0]  en_char_align, lane_aligned, lane_failed;
    logic        busy, done, error;

    int n_checks = 0;
    int n_err    = 0;

    assign rxdata = {lane_data[3], lane_data[2], lane_data[1], lane_data[0]};

    lane_align_sequencer #(
        .NUM_LANES(4), .TIMEOUT_CYCLES(64), .STABLE_CYCLES(16), .MAX_RETRIES(2)
    ) dut (
        .usr_clk(usr_clk), .reset(reset), .start(start), .rxdata(rxdata),
        .en_char_align(en_char_align), .lane_aligned(lane_aligned),
        .lane_failed(lane_failed), .busy(busy), .done(done), .error(error)
    );

    always #5 usr_clk = ~usr_clk;

    task automatic tick();
        @(posedge usr_clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic chk_status(input string tag, input logic [3:0] al, input logic [3:0] fl,
                              input logic dn, input logic er, input logic bz, input logic [3:0] en);
        chk({tag, ".aligned"}, 32'(lane_aligned), 32'(al));
        chk({tag, ".failed"},  32'(lane_failed),  32'(fl));
        chk({tag, ".done"},    32'(done),         32'(dn));
        chk({tag, ".error"},   32'(error),        32'(er));
        chk({tag, ".busy"},    32'(busy),         32'(bz));
        chk({tag, ".en"},      32'(en_char_align), 32'(en));
    endtask

    // Test 2 expected enable: lanes 0/1 lock fast, lane 2 gets 3 windows of 64 with 4-cycle gaps.
    function automatic logic [3:0] en_t2(input int c);
        if (c <= 16)  return 4'b0001;
        if (c <= 32)  return 4'b0010;
        if (c <= 96)  return 4'b0100;
        if (c <= 100) return 4'b0000;
        if (c <= 164) return 4'b0100;
        if (c <= 168) return 4'b0000;
        if (c <= 232) return 4'b0100;
        if (c <= 248) return 4'b1000;
        return 4'b0000;
    endfunction

    initial begin
        for (int i = 0; i < 4; i++) lane_data[i] = COMMA;

        // Reset state
        tick(); tick();
        chk_status("reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        tick();
        chk_status("idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);

        // Test 1: all lanes comma; a start pulse at cycle 20 (busy) must be ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            chk($sformatf("t1.en[c%0d]", c), 32'(en_char_align), 32'(4'b0001 << ((c - 1) / 16)));
            chk($sformatf("t1.busy[c%0d]", c), 32'(busy), 32'd1);
            start = (c == 20);
            tick();
        end
        start = 1'b0;
        chk_status("t1.end", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);

        // Test 2 (also restart from done): lane 2 never commas
        lane_data[2] = BAD;
        start = 1'b1;
        tick();
        start = 1'b0;
        chk_status("t2.restart", 4'h0, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0001);
        for (int c = 1; c <= 248; c++) begin
            chk($sformatf("t2.en[c%0d]", c), 32'(en_char_align), 32'(en_t2(c)));
            tick();
        end
        chk_status("t2.end", 4'b1011, 4'b0100, 1'b1, 1'b1, 1'b0, 4'h0);
        lane_data[2] = COMMA;

        // Test 3: lane 0 has 15 commas, one bad word, then commas -> lock at cycle 32
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 80; c++) begin
            lane_data[0] = (c == 16) ? BAD : COMMA;
            if (c == 32) chk("t3.en_pre_lock", 32'(en_char_align), 32'h1);
            if (c == 33) chk("t3.en_post_lock", 32'(en_char_align), 32'h2);
            tick();
        end
        chk_status("t3.end", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);

        // Test 4: lock lands on the last timer cycle (cycle 64), then test 5 resets on lane 1
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 69; c++) begin
            lane_data[0] = (c <= 48) ? BAD : COMMA;
            if (c == 64) chk("t4.en_at_edge", 32'(en_char_align), 32'h1);
            if (c == 65) chk_status("t4.lock", 4'b0001, 4'h0, 1'b0, 1'b0, 1'b1, 4'b0010);
            tick();
        end
        chk("t5.en_lane1", 32'(en_char_align), 32'h2);
        reset = 1'b1;
        tick();
        chk_status("t5.reset", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        reset = 1'b0;
        tick();
        chk_status("t5.idle", 4'h0, 4'h0, 1'b0, 1'b0, 1'b0, 4'h0);
        start = 1'b1;
        tick();
        start = 1'b0;
        for (int c = 1; c <= 64; c++) begin
            if (c == 1 || c == 17) chk($sformatf("t5.en[c%0d]", c), 32'(en_char_align),
                                       32'(4'b0001 << ((c - 1) / 16)));
            tick();
        end
        chk_status("t5.end", 4'hF, 4'h0, 1'b1, 1'b0, 1'b0, 4'h0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
        $finish;
    end
endmodule
